// File: rtl/aes_arbiter_if.sv
// Bundle of requester, AES-datapath and response signals for aes_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface aes_arbiter_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         req0_encrypt;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic         req1_encrypt;
  logic [127:0] aes_in_data;
  logic [127:0] aes_key;
  logic         aes_flag;
  logic [127:0] aes_data_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         busy;
  logic [1:0]   state_dbg;

  modport slave (
    input  req0_valid, req0_data, req0_key, req0_encrypt,
    input  req1_valid, req1_data, req1_key, req1_encrypt,
    input  aes_data_out, rsp_ready,
    output req0_ready, req1_ready,
    output aes_in_data, aes_key, aes_flag,
    output rsp_valid, rsp_data, rsp_id, busy, state_dbg
  );

  modport master (
    output req0_valid, req0_data, req0_key, req0_encrypt,
    output req1_valid, req1_data, req1_key, req1_encrypt,
    output aes_data_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  aes_in_data, aes_key, aes_flag,
    input  rsp_valid, rsp_data, rsp_id, busy, state_dbg
  );
endinterface

// File: rtl/aes_arbiter.sv
// Two-requester round-robin arbiter in front of a shared AES datapath with a
// fixed LATENCY; one operation in flight, result returned on a valid/ready channel.
module aes_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  aes_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Handshakes: a requester transfer happens on a posedge where reqN_valid and
  // reqN_ready are both high; the response transfers where rsp_valid and rsp_ready are.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_id_q, last_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [127:0]     rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [127:0]     in_data_q, in_data_d;
  logic [127:0]     key_q, key_d;
  logic             flag_q, flag_d;

  logic grant_valid;
  logic grant_id;

  // The grant already implies the chosen requester is valid, so grant == accept.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_id_q;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    in_data_d   = in_data_q;
    key_d       = key_q;
    flag_d      = flag_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          in_data_d = grant_id ? bus.req1_data    : bus.req0_data;
          key_d     = grant_id ? bus.req1_key     : bus.req0_key;
          flag_d    = grant_id ? bus.req1_encrypt : bus.req0_encrypt;
          rsp_id_d  = grant_id;
          last_id_d = grant_id;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // The datapath output only reflects the new operands once the count completes.
        if (cnt_q == CNT_LAST) begin
          rsp_data_d  = bus.aes_data_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      in_data_q   <= '0;
      key_q       <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      in_data_q   <= in_data_d;
      key_q       <= key_d;
      flag_q      <= flag_d;
    end
  end

  assign bus.req0_ready  = grant_valid && !grant_id;
  assign bus.req1_ready  = grant_valid && grant_id;
  assign bus.aes_in_data = in_data_q;
  assign bus.aes_key     = key_q;
  assign bus.aes_flag    = flag_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter: LATENCY=1 and LATENCY=3 instances, each fed by
// a behavioural AES datapath that knows the FIPS-197 AES-128 example vector.
module tb_aes_arbiter;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_arbiter_if bus1();
  aes_arbiter_if bus3();

  aes_arbiter #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_arbiter #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;
  logic [128:0] exp_q[$];
  logic         exp_grant_q[$];

  // Known vector in both directions; any other operands get a keyed mix.
  function automatic logic [127:0] aes_model(input logic [127:0] d, input logic [127:0] k,
                                             input logic e);
    if (e && k == KEY && d == PT) return CT;
    if (!e && k == KEY && d == CT) return PT;
    return d ^ k ^ {128{e}};
  endfunction

  logic [127:0] p3 [0:2];
  always_ff @(posedge clk) begin
    bus1.aes_data_out <= aes_model(bus1.aes_in_data, bus1.aes_key, bus1.aes_flag);
    p3[0] <= aes_model(bus3.aes_in_data, bus3.aes_key, bus3.aes_flag);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.aes_data_out = p3[2];

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic drive_idle();
    bus1.req0_valid = 1'b0; bus1.req0_data = '0; bus1.req0_key = '0; bus1.req0_encrypt = 1'b0;
    bus1.req1_valid = 1'b0; bus1.req1_data = '0; bus1.req1_key = '0; bus1.req1_encrypt = 1'b0;
    bus1.rsp_ready  = 1'b1;
    bus3.req0_valid = 1'b0; bus3.req0_data = '0; bus3.req0_key = '0; bus3.req0_encrypt = 1'b0;
    bus3.req1_valid = 1'b0; bus3.req1_data = '0; bus3.req1_key = '0; bus3.req1_encrypt = 1'b0;
    bus3.rsp_ready  = 1'b1;
  endtask

  task automatic wait_rsp(output int cyc, output logic [127:0] data, output logic id);
    cyc = -1; data = '0; id = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        cyc = k; data = bus1.rsp_data; id = bus1.rsp_id;
      end
      @(posedge clk); #1;
      if (cyc > 0) break;
    end
  endtask

  task automatic run_req(input logic id, input logic [127:0] d, input logic [127:0] k,
                         input logic e, output int acc_cyc, output int rsp_cyc,
                         output logic [127:0] rdata, output logic rid);
    acc_cyc = -1; rsp_cyc = -1; rdata = '0; rid = 1'b0;
    if (!id) begin
      bus1.req0_valid = 1'b1; bus1.req0_data = d; bus1.req0_key = k; bus1.req0_encrypt = e;
    end else begin
      bus1.req1_valid = 1'b1; bus1.req1_data = d; bus1.req1_key = k; bus1.req1_encrypt = e;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ((!id && bus1.req0_ready) || (id && bus1.req1_ready)) begin
        acc_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc_cyc >= 0) begin
      @(posedge clk); #1;
    end
    if (!id) bus1.req0_valid = 1'b0;
    else     bus1.req1_valid = 1'b0;
    if (acc_cyc >= 0) wait_rsp(rsp_cyc, rdata, rid);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    bus1.req0_valid = 1'b1;
    bus1.req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {bus1.req0_ready, bus1.req1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.rsp_valid, bus1.rsp_id, bus1.aes_flag, bus1.busy, bus1.state_dbg} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus1.rsp_valid, bus1.rsp_id, bus1.aes_flag, bus1.busy, bus1.state_dbg});
    end
    checks++;
    if ({bus1.rsp_data, bus1.aes_in_data, bus1.aes_key} !== 384'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", bus1.rsp_data, bus1.aes_in_data, bus1.aes_key);
    end
    checks++;
    if ({bus3.busy, bus3.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_lat3: got %b expected 00", {bus3.busy, bus3.rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    int acc, rc; logic [127:0] rd; logic ri;
    run_req(1'b0, PT, KEY, 1'b1, acc, rc, rd, ri);
    checks++;
    if (acc !== 0) begin errors++; $display("FAIL enc_accept: got %0d expected 0", acc); end
    checks++;
    if (rc !== 3) begin errors++; $display("FAIL enc_latency: got %0d expected 3", rc); end
    checks++;
    if (rd !== CT) begin errors++; $display("FAIL enc_data: got %h expected %h", rd, CT); end
    checks++;
    if (ri !== 1'b0) begin errors++; $display("FAIL enc_id: got %b expected 0", ri); end
    checks++;
    if ({bus1.aes_in_data, bus1.aes_key, bus1.aes_flag} !== {PT, KEY, 1'b1}) begin
      errors++;
      $display("FAIL enc_operands_held: got %h %h %b expected %h %h 1",
               bus1.aes_in_data, bus1.aes_key, bus1.aes_flag, PT, KEY);
    end
  endtask

  task automatic test_decrypt();
    int acc, rc; logic [127:0] rd; logic ri;
    run_req(1'b1, CT, KEY, 1'b0, acc, rc, rd, ri);
    checks++;
    if (rc !== 3) begin errors++; $display("FAIL dec_latency: got %0d expected 3", rc); end
    checks++;
    if (rd !== PT) begin errors++; $display("FAIL dec_data: got %h expected %h", rd, PT); end
    checks++;
    if (ri !== 1'b1) begin errors++; $display("FAIL dec_id: got %b expected 1", ri); end
  endtask

  // Pointer now favours requester 0, but only requester 1 is valid.
  task automatic test_lone_requester();
    int acc, rc; logic [127:0] rd; logic ri;
    logic [127:0] d = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    logic [127:0] k = 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
    run_req(1'b1, d, k, 1'b1, acc, rc, rd, ri);
    checks++;
    if (acc !== 0) begin errors++; $display("FAIL lone_accept: got %0d expected 0", acc); end
    checks++;
    if ({ri, rd} !== {1'b1, d ^ k ^ {128{1'b1}}}) begin
      errors++; $display("FAIL lone_rsp: got %b %h expected 1 %h", ri, rd, d ^ k ^ {128{1'b1}});
    end
  endtask

  task automatic test_contention();
    logic [127:0] a  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    logic [127:0] b  = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    logic [127:0] k0 = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    logic [127:0] k1 = 128'h33333333333333333333333333333333;
    int accepts = 0;
    logic gid, eg;
    logic [128:0] got;
    exp_grant_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_q.delete();
    rst = 1'b1;
    bus1.req0_valid = 1'b1; bus1.req0_data = a; bus1.req0_key = k0; bus1.req0_encrypt = 1'b1;
    bus1.req1_valid = 1'b1; bus1.req1_data = b; bus1.req1_key = k1; bus1.req1_encrypt = 1'b0;
    bus1.rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus1.req0_ready && bus1.req1_ready) begin
        errors++; $display("FAIL cont_dual_ready: cycle %0d both readys high", c);
      end
      if (bus1.busy) begin
        checks++;
        if (bus1.req0_ready || bus1.req1_ready) begin
          errors++; $display("FAIL cont_ready_busy: cycle %0d ready while busy", c);
        end
      end
      if (bus1.req0_ready || bus1.req1_ready) begin
        accepts++;
        gid = bus1.req1_ready;
        eg  = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : ~gid;
        checks++;
        if (gid !== eg) begin
          errors++; $display("FAIL cont_grant: cycle %0d got %b expected %b", c, gid, eg);
        end
        exp_q.push_back(eg ? {1'b1, aes_model(b, k1, 1'b0)} : {1'b0, aes_model(a, k0, 1'b1)});
      end
      if (bus1.rsp_valid) begin
        got = {bus1.rsp_id, bus1.rsp_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL cont_rsp: cycle %0d got %h expected none", c, got);
        end else if (got !== exp_q[0]) begin
          errors++; $display("FAIL cont_rsp: cycle %0d got %h expected %h", c, got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    checks++;
    if (accepts !== 5) begin errors++; $display("FAIL cont_accepts: got %0d expected 5", accepts); end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL cont_pending: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int acc, rc; logic [127:0] rd; logic ri;
    logic [127:0] d = 128'h0123456789abcdef0123456789abcdef;
    logic [127:0] k = 128'h55555555aaaaaaaa55555555aaaaaaaa;
    logic [127:0] exp_d = d ^ k ^ {128{1'b1}};
    bus1.rsp_ready = 1'b0;
    run_req(1'b0, d, k, 1'b1, acc, rc, rd, ri);
    checks++;
    if ({rc == 3, ri, rd} !== {1'b1, 1'b0, exp_d}) begin
      errors++; $display("FAIL bp_first: got %0d %b %h expected 3 0 %h", rc, ri, rd, exp_d);
    end
    bus1.req1_valid = 1'b1; bus1.req1_data = d; bus1.req1_key = k; bus1.req1_encrypt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data} !== {1'b1, 1'b0, exp_d}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got %b %b %h expected 1 0 %h",
                 c, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, exp_d);
      end
      checks++;
      if ({bus1.req0_ready, bus1.req1_ready, bus1.busy} !== 3'b001) begin
        errors++;
        $display("FAIL bp_ready_busy: cycle %0d got %b expected 001",
                 c, {bus1.req0_ready, bus1.req1_ready, bus1.busy});
      end
      @(posedge clk); #1;
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.rsp_valid, bus1.req0_ready, bus1.req1_ready} !== 3'b100) begin
      errors++;
      $display("FAIL bp_handshake: got %b expected 100", {bus1.rsp_valid, bus1.req0_ready, bus1.req1_ready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus1.busy, bus1.rsp_valid, bus1.req1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_idle_next: got %b expected 001", {bus1.busy, bus1.rsp_valid, bus1.req1_ready});
    end
    @(posedge clk); #1;
    bus1.req1_valid = 1'b0;
    wait_rsp(rc, rd, ri);
    checks++;
    if ({rc == 3, ri, rd} !== {1'b1, 1'b1, d ^ k}) begin
      errors++; $display("FAIL bp_second: got %0d %b %h expected 3 1 %h", rc, ri, rd, d ^ k);
    end
  endtask

  task automatic test_mid_reset();
    int rc; logic [127:0] rd; logic ri;
    logic [127:0] x = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    logic [127:0] y = 128'h00000000ffffffff00000000ffffffff;
    bus1.req0_valid = 1'b1; bus1.req0_data = PT; bus1.req0_key = KEY; bus1.req0_encrypt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.req0_ready !== 1'b1) begin errors++; $display("FAIL mr_accept: got %b expected 1", bus1.req0_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus1.req0_data = x; bus1.req0_key = y; bus1.req0_encrypt = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mr_rst_cycle: got %b expected 000", {bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.rsp_valid, bus1.rsp_id, bus1.aes_flag, bus1.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mr_ctrl: got %b expected 0000", {bus1.rsp_valid, bus1.rsp_id, bus1.aes_flag, bus1.busy});
    end
    checks++;
    if ({bus1.rsp_data, bus1.aes_in_data, bus1.aes_key} !== 384'h0) begin
      errors++;
      $display("FAIL mr_data: got %h %h %h expected zeros", bus1.rsp_data, bus1.aes_in_data, bus1.aes_key);
    end
    checks++;
    if (bus1.req0_ready !== 1'b1) begin
      errors++; $display("FAIL mr_first_accept: got %b expected 1", bus1.req0_ready);
    end
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0;
    wait_rsp(rc, rd, ri);
    checks++;
    if ({rc == 3, ri, rd} !== {1'b1, 1'b0, x ^ y}) begin
      errors++; $display("FAIL mr_rsp: got %0d %b %h expected 3 0 %h", rc, ri, rd, x ^ y);
    end
  endtask

  task automatic test_latency3();
    int cyc = -1;
    logic [127:0] rd = '0;
    logic ri = 1'b1;
    bus3.req0_valid = 1'b1; bus3.req0_data = PT; bus3.req0_key = KEY; bus3.req0_encrypt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus3.req0_ready !== 1'b1) begin errors++; $display("FAIL l3_accept: got %b expected 1", bus3.req0_ready); end
    @(posedge clk); #1;
    bus3.req0_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus3.rsp_valid) begin
        cyc = k; rd = bus3.rsp_data; ri = bus3.rsp_id;
      end
      @(posedge clk); #1;
      if (cyc > 0) break;
    end
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL l3_latency: got %0d expected 5", cyc); end
    checks++;
    if ({ri, rd} !== {1'b0, CT}) begin
      errors++; $display("FAIL l3_rsp: got %b %h expected 0 %h", ri, rd, CT);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_lone_requester();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
